// File: rtl/cnna_mul_arb_pkg.sv
// rtl/cnna_mul_arb_pkg.sv - shared widths, output-state enum and index-width helper
package cnna_mul_arb_pkg;

  localparam int A_W = 13;
  localparam int B_W = 5;
  localparam int P_W = 18;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Index width for n requesters; never below 1 so a port always exists.
  function automatic int idw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cnna_mul_mul_13ns_5ns_18_1_1.sv
// rtl/cnna_mul_mul_13ns_5ns_18_1_1.sv - combinational 13x5 unsigned multiplier cell, 18-bit product
module cnna_mul_mul_13ns_5ns_18_1_1 (
  input  logic [12:0] din0,
  input  logic [4:0]  din1,
  output logic [17:0] dout
);

  assign dout = 18'(din0) * 18'(din1);

endmodule

// File: rtl/cnna_mul_rr_pick.sv
// rtl/cnna_mul_rr_pick.sv - combinational round-robin picker starting at ptr
module cnna_mul_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any_valid
);

  logic found;
  int   c;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = |req;
    found     = 1'b0;
    c         = 0;
    // Walk upward from ptr, wrapping; the first set bit wins.
    for (int k = 0; k < NREQ; k++) begin
      c = (int'(ptr) + k) % NREQ;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IDW'(c);
      end
    end
  end

endmodule

// File: rtl/cnna_mul_arbiter.sv
// rtl/cnna_mul_arbiter.sv - round-robin sharing of one 13x5 multiplier across NREQ requesters
module cnna_mul_arbiter
  import cnna_mul_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_of(NREQ)
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*A_W-1:0] req_a,
  input  logic [NREQ*B_W-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic                rsp_valid,
  output logic [P_W-1:0]      rsp_data,
  output logic [IDW-1:0]      rsp_id,
  input  logic                rsp_ready,
  output logic [31:0]         op_count
);

  out_state_t       state_q, state_d;
  logic [IDW-1:0]   ptr_q;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   win;
  logic             any_valid;
  logic             can_load;
  logic             req_xfer;
  logic             rsp_xfer;
  logic [A_W-1:0]   mul_a;
  logic [B_W-1:0]   mul_b;
  logic [P_W-1:0]   mul_p;

  cnna_mul_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (win),
    .any_valid (any_valid)
  );

  assign rsp_valid = (state_q == FULL);
  assign can_load  = (state_q == EMPTY) || rsp_ready;
  assign req_ready = (can_load && !ap_rst) ? grant : '0;
  assign req_xfer  = can_load && any_valid && !ap_rst;
  assign rsp_xfer  = rsp_valid && rsp_ready;

  assign mul_a = req_a[int'(win)*A_W +: A_W];
  assign mul_b = req_b[int'(win)*B_W +: B_W];

  cnna_mul_mul_13ns_5ns_18_1_1 u_mul (
    .din0 (mul_a),
    .din1 (mul_b),
    .dout (mul_p)
  );

  // A new load wins over a drain, which gives same-cycle pass-through.
  always_comb begin
    state_d = state_q;
    if (req_xfer) begin
      state_d = FULL;
    end else if (rsp_xfer) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q  <= EMPTY;
      ptr_q    <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      if (req_xfer) begin
        rsp_data <= mul_p;
        rsp_id   <= win;
        ptr_q    <= (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
      end
      if (rsp_xfer) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_cnna_mul_arbiter.sv
// tb/tb_cnna_mul_arbiter.sv - directed scoreboard bench for cnna_mul_arbiter
module tb_cnna_mul_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [51:0] req_a;
  logic [19:0] req_b;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [17:0] rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_ready;
  logic [31:0] op_count;

  logic [12:0] op_a [4];
  logic [4:0]  op_b [4];

  int          qid[$];
  logic [17:0] qdata[$];
  logic [31:0] exp_cnt;
  int          tests = 0;
  int          fails = 0;

  cnna_mul_arbiter #(.NREQ(4), .IDW(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .op_count  (op_count)
  );

  always #5 ap_clk = ~ap_clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < 4; i++) begin
      req_a[13*i +: 13] = op_a[i];
      req_b[5*i +: 5]   = op_b[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check handshake and scoreboard, then advance past the edge.
  task automatic step(input logic [3:0] v, input int g, input logic rr);
    logic [3:0]  exp_rdy;
    logic [17:0] prod;
    req_valid = v;
    rsp_ready = rr;
    #1;
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("op_count", op_count, exp_cnt);
    chk("rsp_valid", 32'(rsp_valid), 32'(qid.size() != 0));
    if (qid.size() != 0 && rsp_valid === 1'b1) begin
      chk("rsp_id", 32'(rsp_id), 32'(qid[0]));
      chk("rsp_data", 32'(rsp_data), 32'(qdata[0]));
      if (rr) begin
        void'(qid.pop_front());
        void'(qdata.pop_front());
        exp_cnt = exp_cnt + 32'd1;
      end
    end
    if (g >= 0) begin
      prod = 18'(op_a[g]) * 18'(op_b[g]);
      qid.push_back(g);
      qdata.push_back(prod);
    end
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] v);
    ap_rst    = 1'b1;
    req_valid = v;
    rsp_ready = 1'b1;
    #1;
    chk("req_ready_in_reset", 32'(req_ready), 32'h0);
    @(posedge ap_clk);
    #1;
    ap_rst    = 1'b0;
    req_valid = '0;
    qid.delete();
    qdata.delete();
    exp_cnt = '0;
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
  endtask

  initial begin
    ap_rst    = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    exp_cnt   = '0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = '0;
      op_b[i] = '0;
    end

    // Reset and single requester at operand maxima
    do_reset(4'b1111);
    op_a[2] = 13'd8191;
    op_b[2] = 5'd31;
    step(4'b0100, 2, 1'b1);
    step(4'b0000, -1, 1'b1);
    step(4'b0000, -1, 1'b1);

    // All four valid: strict rotation with pass-through
    do_reset(4'b0000);
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 13'(i + 1);
      op_b[i] = 5'd3;
    end
    for (int k = 0; k < 8; k++) step(4'b1111, k % 4, 1'b1);
    step(4'b0000, -1, 1'b1);
    chk("op_count_after_8", op_count, 32'd8);

    // Backpressure while requesters 1 and 3 wait
    step(4'b0010, 1, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b1010, -1, 1'b0);
    step(4'b1010, 3, 1'b1);
    step(4'b0010, 1, 1'b1);
    step(4'b0000, -1, 1'b1);

    // Pointer continuity: 0 then 1, then 0 again skipping 2 and 3
    step(4'b0011, 0, 1'b1);
    step(4'b0010, 1, 1'b1);
    step(4'b0001, 0, 1'b1);
    step(4'b0000, -1, 1'b1);

    // Reset while holding a result from requester 3
    step(4'b1000, 3, 1'b0);
    step(4'b0000, -1, 1'b0);
    chk("held_rsp_id", 32'(rsp_id), 32'd3);
    do_reset(4'b1001);
    step(4'b1001, 0, 1'b1);
    step(4'b1000, 3, 1'b1);
    step(4'b0000, -1, 1'b1);

    // Counter wrap from a preloaded all-ones value
    force dut.op_count = 32'hFFFF_FFFF;
    #1;
    release dut.op_count;
    exp_cnt = 32'hFFFF_FFFF;
    step(4'b0100, 2, 1'b1);
    step(4'b0000, -1, 1'b1);
    step(4'b0000, -1, 1'b1);
    chk("op_count_wrapped", op_count, 32'h0);

    chk("scoreboard_empty", 32'(qid.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
